// File: rtl/rca_seq_adder_pkg.sv
// Shared types and constants for the word-serial ripple-carry adder.
// Holds the FSM encoding, the slice width and the signed-overflow rule.
package rca_seq_adder_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Operands of equal sign producing a result of the opposite sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/rca_seq_adder_if.sv
// Request/response bundle of the word-serial adder.
// slave is the adder side, master is the requester/consumer side.
interface rca_seq_adder_if
  import rca_seq_adder_pkg::*;
#(
  parameter int unsigned WORDS = 4
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [WORD_W*WORDS-1:0]   src1;
  logic [WORD_W*WORDS-1:0]   src2;
  logic                      sub_flag;
  logic                      out_valid;
  logic                      out_ready;
  logic [WORD_W*WORDS-1:0]   sum;
  logic                      carry_out;
  logic                      overflow;

  modport slave (
    input  in_valid,
    input  src1,
    input  src2,
    input  sub_flag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output carry_out,
    output overflow
  );

  modport master (
    output in_valid,
    output src1,
    output src2,
    output sub_flag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  carry_out,
    input  overflow
  );

endinterface

// File: rtl/rca_16.sv
// 16-bit ripple-carry adder slice; sub_flag acts as the carry-in.
module rca_16
  import rca_seq_adder_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              sub_flag,
  output logic [WORD_W-1:0] sum,
  output logic              carry_out
);

  logic [WORD_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = sub_flag;
    for (int k = 0; k < WORD_W; k++) begin
      sum[k]   = a[k] ^ b[k] ^ c[k];
      c[k + 1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end
    carry_out = c[WORD_W];
  end

endmodule

// File: rtl/rca_seq_adder.sv
// Word-serial add/subtract: one rca_16 slice reused over WORDS cycles, LS word first.
// Operands are captured on accept; the result is held until the consumer takes it.
module rca_seq_adder
  import rca_seq_adder_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input logic            clk,
  input logic            rst,
  rca_seq_adder_if.slave bus
);

  localparam int unsigned W    = WORD_W * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e state_q, state_d;

  logic [IdxW-1:0] idx_q;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic [W-1:0]    sum_q;
  logic            sub_q;
  logic            carry_q;
  logic            cout_q;
  logic            ovf_q;

  logic              accept;
  logic              run;
  logic              run_last;
  logic [WORD_W-1:0] slice_a;
  logic [WORD_W-1:0] slice_b;
  logic [WORD_W-1:0] slice_sum;
  logic              slice_cin;
  logic              slice_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept   = (state_q == StIdle) && bus.in_valid;
    run      = (state_q == StRun);
    run_last = run && (idx_q == LastIdx);

    slice_a   = op_a_q[WORD_W*int'(idx_q) +: WORD_W];
    slice_b   = op_b_q[WORD_W*int'(idx_q) +: WORD_W];
    // Word 0 takes the +1 of the two's-complement negate; later words chain the carry.
    slice_cin = (idx_q == '0) ? sub_q : carry_q;

    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.sum       = sum_q;
    bus.carry_out = cout_q;
    bus.overflow  = ovf_q;
  end

  rca_16 u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .sub_flag  (slice_cin),
    .sum       (slice_sum),
    .carry_out (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      op_a_q <= bus.src1;
      op_b_q <= bus.sub_flag ? ~bus.src2 : bus.src2;
      sub_q  <= bus.sub_flag;
      idx_q  <= '0;
    end else if (run) begin
      sum_q[WORD_W*int'(idx_q) +: WORD_W] <= slice_sum;
      carry_q <= slice_cout;
      if (run_last) begin
        cout_q <= slice_cout;
        ovf_q  <= signed_ovf(op_a_q[W-1], op_b_q[W-1], slice_sum[WORD_W-1]);
      end else begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

endmodule

// File: doc/rca_seq_adder.md
RCA_SEQ_ADDER -- requirements
Module: rca_seq_adder

Interface
REQ-001 The block SHALL have parameter WORDS, default 4, meaning the number of 16-bit words per operand (operand width W = 16*WORDS).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have ports src1 and src2, input, W bits each: operands.
REQ-007 The block SHALL have port sub_flag, input, 1 bit: 1 selects src1 - src2, 0 selects src1 + src2.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port sum, output, W bits: result.
REQ-011 The block SHALL have port carry_out, output, 1 bit: final carry (for subtract, 1 = no borrow).
REQ-012 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow of the operation.

Function
REQ-013 The block SHALL use one 16-bit adder slice, time-multiplexed over WORDS cycles, least-significant word first.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-015 in_ready SHALL equal (state == IDLE); a request SHALL be accepted on a clock edge where in_valid && in_ready.
REQ-016 On acceptance, the block SHALL register src1, src2 and sub_flag, clear the word index to 0, and go to RUN.
REQ-017 The registered src2 SHALL be bitwise inverted when sub_flag = 1.
REQ-018 In RUN, word index i SHALL drive the slice with operand words [16i+15:16i].
REQ-019 The slice carry-in (the slice's sub_flag port) SHALL be the registered sub_flag when i = 0, and the carry register otherwise.
REQ-020 At each RUN edge, the block SHALL store the slice sum into sum word i, store the slice carry_out into the carry register, and increment i.
REQ-021 At the RUN edge with i = WORDS-1, the block SHALL go to DONE, drive carry_out from the final carry, and set overflow = (a_msb == beff_msb) && (sum_msb != a_msb), where beff is the possibly-inverted src2.
REQ-022 Latency: out_valid SHALL rise exactly WORDS cycles after the accepting edge; the index SHALL never exceed WORDS-1, with no wrap.
REQ-023 In DONE, out_valid SHALL be 1 and sum, carry_out and overflow SHALL be held stable until out_ready = 1; the edge with out_valid && out_ready SHALL return to IDLE.
REQ-024 There SHALL be no overlap between requests: in_ready is 0 during RUN and DONE, and in_valid there is ignored.
REQ-025 Operand input changes after acceptance SHALL NOT affect the result.
REQ-026 WORDS = 1 SHALL be supported: a single RUN cycle.

Reset
REQ-027 With rst = 1 at an edge, the block SHALL go to IDLE, and sum, carry_out, overflow, out_valid, the carry register and the index SHALL all become 0; in_ready SHALL then be 1.
REQ-028 Reset in RUN or DONE SHALL abort the operation and discard it without producing an output.
REQ-029 in_valid coincident with rst SHALL NOT be accepted.

Structure
REQ-030 The shared package SHALL hold the state encoding (IDLE = 0, RUN = 1, DONE = 2, 2-bit) and the constant WORD_W = 16.
REQ-031 There SHALL be one sub-module: rca_16 as the adder slice, with its sub_flag port used as carry-in; all other logic (FSM, index counter, operand/result registers) SHALL be local.

Verification
REQ-032 Add with WORDS = 4: src1 = 64'hFFFF_FFFF_FFFF_FFFF, src2 = 1, sub_flag = 0 -> sum = 0, carry_out = 1, overflow = 0, out_valid 4 cycles after accept.
REQ-033 Subtract: src1 = 5, src2 = 7, sub_flag = 1 -> sum = 64'hFFFF_FFFF_FFFF_FFFE, carry_out = 0, overflow = 0.
REQ-034 Signed overflow: src1 = 64'h7FFF_FFFF_FFFF_FFFF, src2 = 1, add -> sum = 64'h8000_0000_0000_0000, overflow = 1, carry_out = 0.
REQ-035 Backpressure: hold out_ready = 0 for 10 cycles with in_valid = 1 throughout -> out_valid and outputs stay stable, in_ready = 0, no second accept; on out_ready = 1, in_ready rises the next cycle.
REQ-036 Reset in RUN: assert rst at i = 2 -> next cycle in IDLE with all outputs 0 and in_ready = 1, and no out_valid pulse.
REQ-037 Randomized back-to-back add/sub with WORDS = 1 and WORDS = 4 -> sum, carry_out and overflow match a reference model for 1000 transactions.
